mem_host_sequencer: RTL and testbench

- Parametrised host-side sequencer for the downsampling machine.
- Replaces the raw status/data_in/data_addr_in load path with a command plus streaming interface:
  - burst-loads instruction memory or data memory from a valid/ready stream;
  - starts the processor and waits for completion, with a watchdog;
  - streams a result region of data memory back out over valid/ready.
- Sits between the external host and the processor/memory pair at machine top level.

---
 rtl/mem_host_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_mem_host_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_host_sequencer.sv
// Host-side command sequencer: streams words into instruction/data memory, starts the
// processor with a watchdog, and streams a data-memory region back out over valid/ready.
module mem_host_sequencer #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [ADDR_W-1:0]  cmd_base,
  input  logic [ADDR_W-1:0]  cmd_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               dm_we,
  output logic [ADDR_W-1:0]  dm_addr,
  output logic [DATA_W-1:0]  dm_wdata,
  input  logic [DATA_W-1:0]  dm_rdata,
  output logic               proc_start,
  input  logic               proc_done,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {
    IDLE, LOAD_IM, LOAD_DM, RUN_START, RUN_WAIT, RD_ISSUE, RD_WAIT, RD_OUT
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   base_r, base_nxt;
  logic [ADDR_W-1:0]   len_r, len_nxt;
  logic [ADDR_W-1:0]   cnt, cnt_nxt, cnt_inc;
  logic [31:0]         wd_cnt, wd_nxt;
  logic                err_nxt, done_nxt, start_nxt;
  logic                im_we_nxt, dm_we_nxt, out_valid_nxt;
  logic [ADDR_W-1:0]   im_addr_nxt, dm_addr_nxt;
  logic [INSTR_W-1:0]  im_wdata_nxt;
  logic [DATA_W-1:0]   dm_wdata_nxt, out_data_nxt;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign in_ready  = (state == LOAD_IM) || (state == LOAD_DM);
  assign cnt_inc   = cnt + ADDR_W'(1);

  always_comb begin
    state_nxt     = state;
    base_nxt      = base_r;
    len_nxt       = len_r;
    cnt_nxt       = cnt;
    wd_nxt        = wd_cnt;
    err_nxt       = err;
    done_nxt      = 1'b0;
    start_nxt     = 1'b0;
    im_we_nxt     = 1'b0;
    im_addr_nxt   = im_addr;
    im_wdata_nxt  = im_wdata;
    dm_we_nxt     = 1'b0;
    dm_addr_nxt   = dm_addr;
    dm_wdata_nxt  = dm_wdata;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          base_nxt = cmd_base;
          len_nxt  = cmd_len;
          cnt_nxt  = '0;
          err_nxt  = 1'b0;
          case (cmd_op)
            2'b01: if (cmd_len != '0) state_nxt = LOAD_IM; else done_nxt = 1'b1;
            2'b10: if (cmd_len != '0) state_nxt = LOAD_DM; else done_nxt = 1'b1;
            2'b11: begin
              state_nxt = RUN_START;
              start_nxt = 1'b1;
            end
            default: done_nxt = 1'b1;
          endcase
        end
      end
      LOAD_IM: begin
        if (in_valid) begin
          im_we_nxt    = 1'b1;
          im_addr_nxt  = base_r + cnt;
          im_wdata_nxt = in_data;
          cnt_nxt      = cnt_inc;
          if (cnt_inc == len_r) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      LOAD_DM: begin
        if (in_valid) begin
          dm_we_nxt    = 1'b1;
          dm_addr_nxt  = base_r + cnt;
          dm_wdata_nxt = in_data[DATA_W-1:0];
          cnt_nxt      = cnt_inc;
          if (cnt_inc == len_r) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      RUN_START: begin
        state_nxt = RUN_WAIT;
        wd_nxt    = '0;
      end
      // proc_done is checked before the watchdog so a same-cycle completion wins
      RUN_WAIT: begin
        if (proc_done) begin
          if (len_r == '0) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            dm_addr_nxt = base_r + cnt;
            state_nxt   = RD_ISSUE;
          end
        end else if ((TIMEOUT != 0) && (wd_cnt == TIMEOUT - 1)) begin
          err_nxt   = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          wd_nxt = wd_cnt + 32'd1;
        end
      end
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT: begin
        out_data_nxt  = dm_rdata;
        out_valid_nxt = 1'b1;
        state_nxt     = RD_OUT;
      end
      RD_OUT: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          cnt_nxt       = cnt_inc;
          if (cnt_inc == len_r) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            dm_addr_nxt = base_r + cnt_inc;
            state_nxt   = RD_ISSUE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base_r     <= '0;
      len_r      <= '0;
      cnt        <= '0;
      wd_cnt     <= '0;
      err        <= 1'b0;
      done       <= 1'b0;
      proc_start <= 1'b0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      dm_we      <= 1'b0;
      dm_addr    <= '0;
      dm_wdata   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      state      <= state_nxt;
      base_r     <= base_nxt;
      len_r      <= len_nxt;
      cnt        <= cnt_nxt;
      wd_cnt     <= wd_nxt;
      err        <= err_nxt;
      done       <= done_nxt;
      proc_start <= start_nxt;
      im_we      <= im_we_nxt;
      im_addr    <= im_addr_nxt;
      im_wdata   <= im_wdata_nxt;
      dm_we      <= dm_we_nxt;
      dm_addr    <= dm_addr_nxt;
      dm_wdata   <= dm_wdata_nxt;
      out_valid  <= out_valid_nxt;
      out_data   <= out_data_nxt;
    end
  end

endmodule

// File: tb/tb_mem_host_sequencer.sv
// Directed bench for mem_host_sequencer: loads, wrap, reset abort, run/readback,
// watchdog and busy/len-0 command handling against hand-computed values.
module tb_mem_host_sequencer;
  localparam int DATA_W = 8, INSTR_W = 16, ADDR_W = 16, TIMEOUT = 20;

  logic               clk = 1'b0, rst = 1'b1;
  logic               cmd_valid = 1'b0, cmd_ready;
  logic [1:0]         cmd_op = '0;
  logic [ADDR_W-1:0]  cmd_base = '0, cmd_len = '0;
  logic               in_valid = 1'b0, in_ready;
  logic [INSTR_W-1:0] in_data = '0;
  logic               out_valid, out_ready = 1'b0;
  logic [DATA_W-1:0]  out_data;
  logic               im_we, dm_we, proc_start, proc_done = 1'b0, busy, done, err;
  logic [ADDR_W-1:0]  im_addr, dm_addr;
  logic [INSTR_W-1:0] im_wdata;
  logic [DATA_W-1:0]  dm_wdata, dm_rdata = '0;

  mem_host_sequencer #(.DATA_W(DATA_W), .INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .proc_start(proc_start), .proc_done(proc_done),
    .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  // Synchronous-read data memory image used for the readback test
  always @(posedge clk)
    dm_rdata <= (dm_addr == 16'h0100) ? 8'h5A : (dm_addr == 16'h0101) ? 8'hC3 : 8'h00;

  logic [31:0] im_log[$];
  logic        im_done_log[$];
  logic [31:0] dm_log[$];
  int          done_cnt = 0, start_cnt = 0;

  always @(negedge clk) begin
    if (im_we) begin
      im_log.push_back({im_addr, im_wdata});
      im_done_log.push_back(done);
    end
    if (dm_we) dm_log.push_back({8'h00, dm_addr, dm_wdata});
    if (done) done_cnt++;
    if (proc_start) start_cnt++;
  end

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [15:0] base, input logic [15:0] len);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_base = base; cmd_len = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] w, input bit gap);
    if (gap) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1; in_data = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    if (!out_valid) check(tag, 32'(out_valid), 32'd1);
  endtask

  logic [15:0] words[4];
  int d0, s0, n;

  initial begin
    // Reset state
    tick(); tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outs", {26'd0, im_we, dm_we, in_ready, out_valid, proc_start, done}, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();

    // IM burst with gaps, plus a command offered while busy
    im_log.delete(); im_done_log.delete(); dm_log.delete();
    d0 = done_cnt;
    send_cmd(2'b01, 16'h0010, 16'd3);
    check("im_in_ready", 32'(in_ready), 32'd1);
    check("im_cmd_ready", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_base = 16'h0200; cmd_len = 16'd1;
    tick();
    cmd_valid = 1'b0;
    push_word(16'hA001, 1'b1);
    push_word(16'hA002, 1'b1);
    push_word(16'hA003, 1'b1);
    check("im_in_ready_drop", 32'(in_ready), 32'd0);
    tick(); tick();
    check("im_count", 32'(im_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < im_log.size(); i++) begin
      check($sformatf("im_wr%0d", i), im_log[i], {16'h0010 + 16'(i), 16'hA001 + 16'(i)});
      check($sformatf("im_done%0d", i), 32'(im_done_log[i]), (i == 2) ? 32'd1 : 32'd0);
    end
    check("im_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("busy_cmd_ignored", 32'(dm_log.size()), 32'd0);

    // DM load wrapping past 0xFFFF; upper input bits discarded
    dm_log.delete();
    send_cmd(2'b10, 16'hFFFE, 16'd4);
    for (int i = 0; i < 4; i++) push_word(16'hAB11 + 16'(i), 1'b0);
    tick(); tick();
    words = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    check("dm_count", 32'(dm_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < dm_log.size(); i++)
      check($sformatf("dm_wr%0d", i), dm_log[i], {8'h00, words[i], 8'h11 + 8'(i)});

    // Reset mid DM load after 2 of 4 words
    d0 = done_cnt;
    send_cmd(2'b10, 16'h0040, 16'd4);
    push_word(16'h0001, 1'b0);
    push_word(16'h0002, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_dm_we", 32'(dm_we), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check("arst_no_done", 32'(done_cnt - d0), 32'd0);

    // Run + readback with a back-pressured first word
    s0 = start_cnt;
    send_cmd(2'b11, 16'h0100, 16'd2);
    check("run_start", 32'(proc_start), 32'd1);
    for (int i = 0; i < 10; i++) tick();
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    wait_out_valid("rd0_timeout");
    check("rd0_data", 32'(out_data), 32'h5A);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rd0_hold%0d", i), {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h5A});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("rd0_no_done", 32'(done), 32'd0);
    wait_out_valid("rd1_timeout");
    check("rd1_data", 32'(out_data), 32'hC3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("rd_done", 32'(done), 32'd1);
    check("rd_idle", 32'(busy), 32'd0);
    check("run_single_start", 32'(start_cnt - s0), 32'd1);

    // Watchdog: no proc_done; done appears 20 cycles into RUN_WAIT
    send_cmd(2'b11, 16'h0000, 16'd1);
    check("wd_start", 32'(proc_start), 32'd1);
    n = 0;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    check("wd_latency", 32'(n), 32'd21);
    check("wd_err", 32'(err), 32'd1);
    tick(); tick();
    check("wd_err_sticky", 32'(err), 32'd1);
    check("wd_idle", 32'(busy), 32'd0);
    send_cmd(2'b00, 16'h0000, 16'd0);
    check("nop_err_clear", 32'(err), 32'd0);
    check("nop_done", 32'(done), 32'd1);

    // DM load with len 0: done next cycle, no write
    tick();
    dm_log.delete();
    send_cmd(2'b10, 16'h0300, 16'd0);
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    tick();
    check("len0_done_drop", 32'(done), 32'd0);
    check("len0_no_we", 32'(dm_log.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
